// File: rtl/uart_pkg.sv
// Shared UART constants, capture-FSM state encoding and the stored receive-entry layout.
package uart_pkg;

  localparam int unsigned UART_DATA_W       = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 5208;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_LOW
  } rx_buf_state_t;

  typedef struct packed {
    logic                   parity_err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; a push into a full
// FIFO succeeds only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter  int unsigned WIDTH  = 9,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// Captures each byte reported by uart_top into a FWFT FIFO, acknowledges with a one-cycle
// clearInterrupt pulse, and tracks a sticky overflow flag for bytes dropped while full.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter  int unsigned DATA_W = UART_DATA_W,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] receivedData,
  input  logic              rxInterrupt,
  input  logic              parityError,
  output logic              clearInterrupt,
  input  logic              rdEn,
  output logic [DATA_W-1:0] rdData,
  output logic              rdParityErr,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clrOverflow
);

  rx_buf_state_t state;
  rx_buf_state_t next_state;
  logic          capture;

  assign capture = (state == IDLE) && rxInterrupt;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (rxInterrupt) next_state = ACK;
      ACK:      next_state = WAIT_LOW;
      WAIT_LOW: if (!rxInterrupt) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // The ack is registered off the capture condition, so it is high exactly while in ACK;
  // a dropped byte is still acknowledged so uart_top never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      clearInterrupt <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state          <= next_state;
      clearInterrupt <= capture;
      if (capture && full && !rdEn) overflow <= 1'b1;
      else if (clrOverflow)         overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (rdEn),
    .din   ({parityError, receivedData}),
    .dout  ({rdParityErr, rdData}),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed table-driven bench for uart_rx_buffer plus hand-written multi-cycle sequences.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] receivedData;
  logic       rxInterrupt;
  logic       parityError;
  logic       clearInterrupt;
  logic       rdEn;
  logic [7:0] rdData;
  logic       rdParityErr;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       clrOverflow;

  int checks = 0;
  int passes = 0;

  always #10 clk = ~clk;

  uart_rx_buffer #(.DATA_W(8), .DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .receivedData   (receivedData),
    .rxInterrupt    (rxInterrupt),
    .parityError    (parityError),
    .clearInterrupt (clearInterrupt),
    .rdEn           (rdEn),
    .rdData         (rdData),
    .rdParityErr    (rdParityErr),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overflow       (overflow),
    .clrOverflow    (clrOverflow)
  );

  typedef struct {
    logic       rx;
    logic [7:0] d;
    logic       p;
    logic       rd;
    logic       clr_ov;
    int         e_count;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_data;
    logic       e_par;
    logic       e_ov;
    logic       e_ack;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic p);
    @(negedge clk);
    rxInterrupt = 1'b1; receivedData = d; parityError = p;
    @(posedge clk); #1;
    chk($sformatf("ack on push %0h", d), int'(clearInterrupt), 1);
    @(negedge clk);
    rxInterrupt = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("ack low after push %0h", d), int'(clearInterrupt), 0);
    @(posedge clk); #1;
  endtask

  task automatic pop_check(input logic [7:0] d, input logic p);
    @(negedge clk);
    chk($sformatf("pop data exp %0h", d), int'(rdData), int'(d));
    chk($sformatf("pop parity exp %0h", d), int'(rdParityErr), int'(p));
    rdEn = 1'b1;
    @(negedge clk);
    rdEn = 1'b0;
  endtask

  int acks;

  initial begin
    rst = 1'b1; rxInterrupt = 1'b0; receivedData = '0; parityError = 1'b0;
    rdEn = 1'b0; clrOverflow = 1'b0;

    //        rx d      p rd co cnt emp full data  par ov ack
    vecs[0]  = '{1, 8'hFE, 0, 0, 0, 1, 0, 0, 8'hFE, 0, 0, 1};
    vecs[1]  = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 8'hFE, 0, 0, 0};
    vecs[2]  = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 8'hFE, 0, 0, 0};
    vecs[3]  = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0};
    vecs[4]  = '{1, 8'h03, 1, 0, 0, 1, 0, 0, 8'h03, 1, 0, 1};
    vecs[5]  = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h03, 1, 0, 0};
    vecs[6]  = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h03, 1, 0, 0};
    vecs[7]  = '{1, 8'h2E, 0, 0, 0, 2, 0, 0, 8'h03, 1, 0, 1};
    vecs[8]  = '{0, 8'h00, 0, 0, 0, 2, 0, 0, 8'h03, 1, 0, 0};
    vecs[9]  = '{0, 8'h00, 0, 0, 0, 2, 0, 0, 8'h03, 1, 0, 0};
    vecs[10] = '{0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h2E, 0, 0, 0};
    vecs[11] = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0};
    vecs[12] = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0};
    vecs[13] = '{1, 8'h11, 0, 1, 0, 1, 0, 0, 8'h11, 0, 0, 1};
    vecs[14] = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h11, 0, 0, 0};
    vecs[15] = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h11, 0, 0, 0};
    vecs[16] = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset empty", int'(empty), 1);
    chk("reset count", int'(count), 0);
    chk("reset full", int'(full), 0);
    chk("reset overflow", int'(overflow), 0);
    chk("reset ack", int'(clearInterrupt), 0);
    chk("reset rdData", int'(rdData), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rxInterrupt = vecs[i].rx; receivedData = vecs[i].d; parityError = vecs[i].p;
      rdEn = vecs[i].rd; clrOverflow = vecs[i].clr_ov;
      @(posedge clk); #1;
      chk($sformatf("vec%0d count", i), int'(count), vecs[i].e_count);
      chk($sformatf("vec%0d empty", i), int'(empty), int'(vecs[i].e_empty));
      chk($sformatf("vec%0d full", i), int'(full), int'(vecs[i].e_full));
      chk($sformatf("vec%0d rdData", i), int'(rdData), int'(vecs[i].e_data));
      chk($sformatf("vec%0d rdParityErr", i), int'(rdParityErr), int'(vecs[i].e_par));
      chk($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].e_ov));
      chk($sformatf("vec%0d ack", i), int'(clearInterrupt), int'(vecs[i].e_ack));
    end
    @(negedge clk);
    rxInterrupt = 1'b0; rdEn = 1'b0; clrOverflow = 1'b0;

    // Held interrupt: one push, one ack pulse.
    @(negedge clk);
    rxInterrupt = 1'b1; receivedData = 8'h5A; parityError = 1'b1;
    acks = 0;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      if (clearInterrupt) acks++;
    end
    chk("held ack pulses", acks, 1);
    chk("held count", int'(count), 1);
    @(negedge clk);
    rxInterrupt = 1'b0;
    repeat (2) @(posedge clk);
    pop_check(8'h5A, 1'b1);

    // Fill and overflow.
    for (int i = 0; i < 8; i++) push_byte(8'(i), 1'(i & 1));
    chk("fill full", int'(full), 1);
    chk("fill count", int'(count), 8);
    push_byte(8'hAA, 1'b0);
    chk("overflow set", int'(overflow), 1);
    chk("overflow count", int'(count), 8);
    @(negedge clk); clrOverflow = 1'b1;
    @(negedge clk); clrOverflow = 1'b0;
    chk("overflow cleared", int'(overflow), 0);
    @(negedge clk);
    rxInterrupt = 1'b1; receivedData = 8'hBB; clrOverflow = 1'b1;
    @(posedge clk); #1;
    chk("set wins over clear", int'(overflow), 1);
    chk("dropped byte acked", int'(clearInterrupt), 1);
    @(negedge clk);
    rxInterrupt = 1'b0; clrOverflow = 1'b1;
    @(negedge clk); clrOverflow = 1'b0;
    chk("overflow cleared again", int'(overflow), 0);
    for (int i = 0; i < 8; i++) pop_check(8'(i), 1'(i & 1));
    chk("drained empty", int'(empty), 1);

    // Full with simultaneous pop and push.
    for (int i = 0; i < 8; i++) push_byte(8'(i), 1'b0);
    @(negedge clk);
    rxInterrupt = 1'b1; receivedData = 8'h55; parityError = 1'b0; rdEn = 1'b1;
    @(posedge clk); #1;
    chk("full push+pop count", int'(count), 8);
    chk("full push+pop overflow", int'(overflow), 0);
    chk("full push+pop full", int'(full), 1);
    @(negedge clk);
    rxInterrupt = 1'b0; rdEn = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 1; i < 8; i++) pop_check(8'(i), 1'b0);
    pop_check(8'h55, 1'b0);
    chk("after 55 empty", int'(empty), 1);

    // Reset mid-stream with a pending interrupt held high.
    for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i), 1'b0);
    push_byte(8'hAA, 1'b0);
    chk("pre-reset overflow", int'(overflow), 1);
    @(negedge clk);
    rst = 1'b1; rxInterrupt = 1'b1; receivedData = 8'h77; parityError = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset empty", int'(empty), 1);
    chk("midreset count", int'(count), 0);
    chk("midreset overflow", int'(overflow), 0);
    chk("midreset ack", int'(clearInterrupt), 0);
    chk("midreset rdData", int'(rdData), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("recapture ack", int'(clearInterrupt), 1);
    chk("recapture count", int'(count), 1);
    chk("recapture data", int'(rdData), 8'h77);
    chk("recapture parity", int'(rdParityErr), 1);
    @(negedge clk);
    rxInterrupt = 1'b0;
    repeat (2) @(posedge clk);
    pop_check(8'h77, 1'b1);
    chk("final empty", int'(empty), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
